// File: rtl/alu_cmd_sequencer.sv
// Host-side ALU link initiator: serialises SET_A/SET_B/SET_OP/GET_RES bytes to a UART TX and waits for the result byte.
// Optional CMD_SKIP_UNCHANGED_EN: omit SET pairs whose value matches the last acknowledged one.
module alu_cmd_sequencer #(
  parameter int NB_DATA        = 8,
  parameter int NB_ALU_OP      = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [NB_DATA-1:0]   i_A,
  input  logic [NB_DATA-1:0]   i_B,
  input  logic [NB_ALU_OP-1:0] i_op,
  input  logic                 i_tx_done,
  input  logic [NB_DATA-1:0]   i_rx_data,
  input  logic                 i_rx_done,
  output logic                 o_tx_start,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_busy,
  output logic [NB_DATA-1:0]   o_res,
  output logic                 o_res_valid,
  output logic                 o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_TX, S_WAIT_RES} state_t;

  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] skip_q, skip_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, op_q, op_d;
  logic tx_start_q, tx_start_d, busy_q, busy_d, res_valid_q, res_valid_d, timeout_q, timeout_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d, res_q, res_d;
  logic [2:0] skip_start, first_idx, next_idx;
  logic [NB_DATA-1:0] op_ext;

  assign op_ext = NB_DATA'(i_op);

  // Skip mask bit p covers the SET pair at indices 2p (code) and 2p+1 (data).
  function automatic logic [2:0] advance(input logic [2:0] n, input logic [2:0] skip);
    logic [2:0] r;
    r = n;
    for (int i = 0; i < 3; i++)
      if (r < 3'd6 && !r[0] && skip[r[2:1]]) r = r + 3'd2;
    return r;
  endfunction

  function automatic logic [NB_DATA-1:0] byte_sel(input logic [2:0] idx, input logic [NB_DATA-1:0] a,
                                                  input logic [NB_DATA-1:0] b, input logic [NB_DATA-1:0] op);
    case (idx)
      3'd0:    return NB_DATA'(1);
      3'd1:    return a;
      3'd2:    return NB_DATA'(2);
      3'd3:    return b;
      3'd4:    return NB_DATA'(3);
      3'd5:    return op;
      default: return '0;
    endcase
  endfunction

`ifdef CMD_SKIP_UNCHANGED_EN
  logic [NB_DATA-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_op_q, sh_op_d;
  logic [2:0] sh_vld_q, sh_vld_d;

  assign skip_start = {sh_vld_q[2] && (sh_op_q == op_ext),
                       sh_vld_q[1] && (sh_b_q == i_B),
                       sh_vld_q[0] && (sh_a_q == i_A)};

  // A shadow is recorded only once its data byte has been acknowledged.
  always_comb begin
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    sh_op_d  = sh_op_q;
    sh_vld_d = sh_vld_q;
    if (state_q == S_WAIT_TX && i_tx_done && idx_q[0]) begin
      case (idx_q[2:1])
        2'd0:    begin sh_a_d  = a_q;  sh_vld_d[0] = 1'b1; end
        2'd1:    begin sh_b_d  = b_q;  sh_vld_d[1] = 1'b1; end
        default: begin sh_op_d = op_q; sh_vld_d[2] = 1'b1; end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sh_op_q  <= '0;
      sh_vld_q <= '0;
    end else begin
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      sh_op_q  <= sh_op_d;
      sh_vld_q <= sh_vld_d;
    end
  end
`else
  assign skip_start = 3'b000;
`endif

  assign first_idx = advance(3'd0, skip_start);
  assign next_idx  = advance(idx_q + 3'd1, skip_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    skip_d      = skip_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    busy_d      = busy_q;
    res_d       = res_q;
    res_valid_d = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          a_d        = i_A;
          b_d        = i_B;
          op_d       = op_ext;
          skip_d     = skip_start;
          idx_d      = first_idx;
          tx_start_d = 1'b1;
          tx_data_d  = byte_sel(first_idx, i_A, i_B, op_ext);
          busy_d     = 1'b1;
          state_d    = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (i_tx_done) begin
          if (idx_q == 3'd6) begin
            cnt_d   = '0;
            state_d = S_WAIT_RES;
          end else begin
            idx_d      = next_idx;
            tx_start_d = 1'b1;
            tx_data_d  = byte_sel(next_idx, a_q, b_q, op_q);
          end
        end
      end
      S_WAIT_RES: begin
        if (i_rx_done) begin
          res_d       = i_rx_data;
          res_valid_d = 1'b1;
          busy_d      = 1'b0;
          idx_d       = '0;
          state_d     = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          idx_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      skip_q      <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      skip_q      <= skip_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_tx_start  = tx_start_q;
  assign o_tx_data   = tx_data_q;
  assign o_busy      = busy_q;
  assign o_res       = res_q;
  assign o_res_valid = res_valid_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a byte-list protocol model plus a UART responder with random ack/result latencies.
module tb_alu_cmd_sequencer;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       i_reset, i_start, i_tx_done, i_rx_done;
  logic [7:0] i_A, i_B, i_rx_data;
  logic [5:0] i_op;
  logic       o_tx_start, o_busy, o_res_valid, o_timeout;
  logic [7:0] o_tx_data, o_res;

  int checks = 0;
  int errors = 0;
  logic [7:0] res_model = 8'h00;
  logic [7:0] sh_a = 0, sh_b = 0, sh_op = 0;
  logic [2:0] sh_v = 3'b000;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.NB_DATA(8), .NB_ALU_OP(6), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_A(i_A), .i_B(i_B), .i_op(i_op),
    .i_tx_done(i_tx_done), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy), .o_res(o_res),
    .o_res_valid(o_res_valid), .o_timeout(o_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: result after random delay, 1: timeout, 2: result on the terminal timeout cycle
  task automatic run_tx(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                        input int mode, input logic [7:0] rdata, input bit noise);
    logic [7:0] q[$];
    logic [7:0] opx;
    int d;
    opx = {2'b00, op};
`ifdef CMD_SKIP_UNCHANGED_EN
    if (!(sh_v[0] && sh_a == a)) begin q.push_back(8'h01); q.push_back(a); end
    if (!(sh_v[1] && sh_b == b)) begin q.push_back(8'h02); q.push_back(b); end
    if (!(sh_v[2] && sh_op == opx)) begin q.push_back(8'h03); q.push_back(opx); end
    q.push_back(8'h00);
`else
    q = '{8'h01, a, 8'h02, b, 8'h03, opx, 8'h00};
`endif
    i_start = 1'b1; i_A = a; i_B = b; i_op = op;
    tick();
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_tx_start !== 1'b1 || o_tx_data !== q[0]) begin
      errors++;
      $display("FAIL start_accept busy=%b tx_start=%b data=%h expected 1 1 %h", o_busy, o_tx_start, o_tx_data, q[0]);
    end
    for (int j = 0; j < q.size(); j++) begin
      d = $urandom_range(1, 3);
      for (int c = 0; c < d; c++) begin
        if (noise && c == 0) begin
          i_start = 1'b1; i_A = ~a; i_B = ~b; i_rx_done = 1'b1; i_rx_data = ~rdata;
        end
        tick();
        i_start = 1'b0; i_rx_done = 1'b0;
        checks++;
        if (o_tx_start !== 1'b0 || o_res_valid !== 1'b0 || o_busy !== 1'b1) begin
          errors++;
          $display("FAIL tx_gap byte%0d tx_start=%b res_valid=%b busy=%b expected 0 0 1", j, o_tx_start, o_res_valid, o_busy);
        end
      end
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      checks++;
      if (j < q.size() - 1) begin
        if (o_tx_start !== 1'b1 || o_tx_data !== q[j+1]) begin
          errors++;
          $display("FAIL next_byte%0d tx_start=%b data=%h expected 1 %h", j + 1, o_tx_start, o_tx_data, q[j+1]);
        end
      end else if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL last_ack tx_start=%b busy=%b expected 0 1", o_tx_start, o_busy);
      end
    end
    sh_a = a; sh_b = b; sh_op = opx; sh_v = 3'b111;
    if (mode == 0) begin
      d = $urandom_range(0, 5);
      for (int c = 0; c < d; c++) begin
        tick();
        checks++;
        if (o_res_valid !== 1'b0 || o_timeout !== 1'b0 || o_busy !== 1'b1) begin
          errors++;
          $display("FAIL res_wait valid=%b timeout=%b busy=%b expected 0 0 1", o_res_valid, o_timeout, o_busy);
        end
      end
    end else begin
      for (int c = 1; c <= TO - 1; c++) begin
        tick();
        checks++;
        if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin
          errors++;
          $display("FAIL early_timeout cycle%0d timeout=%b busy=%b expected 0 1", c, o_timeout, o_busy);
        end
      end
    end
    if (mode == 1) begin
      tick();
      checks++;
      if (o_timeout !== 1'b1 || o_busy !== 1'b0 || o_res_valid !== 1'b0 || o_res !== res_model) begin
        errors++;
        $display("FAIL timeout timeout=%b busy=%b valid=%b res=%h expected 1 0 0 %h", o_timeout, o_busy, o_res_valid, o_res, res_model);
      end
    end else begin
      i_rx_done = 1'b1; i_rx_data = rdata;
      tick();
      i_rx_done = 1'b0;
      res_model = rdata;
      checks++;
      if (o_res_valid !== 1'b1 || o_timeout !== 1'b0 || o_busy !== 1'b0 || o_res !== res_model) begin
        errors++;
        $display("FAIL result mode%0d valid=%b timeout=%b busy=%b res=%h expected 1 0 0 %h", mode, o_res_valid, o_timeout, o_busy, o_res, res_model);
      end
    end
    tick();
    checks++;
    if (o_res_valid !== 1'b0 || o_timeout !== 1'b0 || o_busy !== 1'b0 || o_tx_start !== 1'b0 || o_res !== res_model) begin
      errors++;
      $display("FAIL post_idle valid=%b timeout=%b busy=%b tx_start=%b res=%h expected 0 0 0 0 %h", o_res_valid, o_timeout, o_busy, o_tx_start, o_res, res_model);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_start = 0; i_tx_done = 0; i_rx_done = 0; i_A = 0; i_B = 0; i_op = 0; i_rx_data = 0;
    repeat (2) tick();
    i_reset = 1'b0;
    checks++;
    if ({o_tx_start, o_tx_data, o_busy, o_res, o_res_valid, o_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs tx_start=%b data=%h busy=%b res=%h valid=%b timeout=%b expected all 0", o_tx_start, o_tx_data, o_busy, o_res, o_res_valid, o_timeout);
    end
  endtask

  task automatic test_idle_ignores();
    i_tx_done = 1'b1; i_rx_done = 1'b1; i_rx_data = 8'hEE;
    tick();
    i_tx_done = 1'b0; i_rx_done = 1'b0;
    tick();
    checks++;
    if (o_tx_start !== 1'b0 || o_res_valid !== 1'b0 || o_busy !== 1'b0 || o_res !== res_model) begin
      errors++;
      $display("FAIL idle_ignore tx_start=%b valid=%b busy=%b res=%h expected 0 0 0 %h", o_tx_start, o_res_valid, o_busy, o_res, res_model);
    end
  endtask

  task automatic test_mid_reset();
    i_start = 1'b1; i_A = 8'h11; i_B = 8'h22; i_op = 6'h05;
    tick();
    i_start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
    end
    checks++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h22) begin
      errors++;
      $display("FAIL pre_reset_byte3 tx_start=%b data=%h expected 1 22", o_tx_start, o_tx_data);
    end
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    res_model = 8'h00;
    sh_v = 3'b000;
    checks++;
    if ({o_tx_start, o_tx_data, o_busy, o_res, o_res_valid, o_timeout} !== '0) begin
      errors++;
      $display("FAIL mid_reset tx_start=%b data=%h busy=%b res=%h valid=%b timeout=%b expected all 0", o_tx_start, o_tx_data, o_busy, o_res, o_res_valid, o_timeout);
    end
    repeat (TO + 2) begin
      tick();
      checks++;
      if (o_timeout !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL after_reset timeout=%b busy=%b expected 0 0", o_timeout, o_busy);
      end
    end
    run_tx(8'h11, 8'h22, 6'h05, 0, 8'h33, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++)
      run_tx(8'($urandom), 8'($urandom), 6'($urandom), int'($urandom_range(0, 2)), 8'($urandom), bit'($urandom_range(0, 1)));
  endtask

  initial begin
    test_reset();
    run_tx(8'h05, 8'h03, 6'h20, 0, 8'h08, 0);
    run_tx(8'h05, 8'h07, 6'h20, 0, 8'h0C, 0);
    run_tx(8'h05, 8'h07, 6'h20, 1, 8'h00, 0);
    run_tx(8'h09, 8'h04, 6'h01, 2, 8'hA5, 0);
    run_tx(8'h09, 8'h04, 6'h02, 0, 8'h5A, 1);
    test_idle_ignores();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
